// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_EMIT
  } padder_state_t;

  localparam logic [31:0] PAD_MARKER    = 32'h8000_0000;
  localparam int          WORDS_PER_BLK = 16;
  localparam int          BLK_W         = 512;

endpackage

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: gathers 32-bit message words into 16-word blocks,
// appends the 0x80000000 marker, zero fill and the 64-bit bit length, and
// hands complete 512-bit blocks to the compression stage one at a time.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLK_W-1:0]   blk_data,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               blk_last,
  output logic               busy,
  output logic               done
);

  padder_state_t    state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             marker_done_q, marker_done_d;
  // Set when the marker landed at word 14 or 15: the length no longer fits
  // in that block, so the rest of it is zero and an extra block follows.
  logic             marker_late_q, marker_late_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [31:0]      buf_q [WORDS_PER_BLK];
  logic [31:0]      buf_d [WORDS_PER_BLK];
  logic [63:0]      len_bits;
  logic [31:0]      pad_word;

  assign len_bits = 64'(len_q) << 5;

  // Word written during PAD: marker first, length in the last two slots of
  // the final block, zeros elsewhere.
  always_comb begin
    pad_word = 32'h0;
    if (!marker_done_q) begin
      pad_word = PAD_MARKER;
    end else if (!marker_late_q && idx_q == 4'd14) begin
      pad_word = len_bits[63:32];
    end else if (!marker_late_q && idx_q == 4'd15) begin
      pad_word = len_bits[31:0];
    end
  end

  // Next-state logic for the FSM, counters and block buffer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rem_d         = rem_q;
    len_d         = len_q;
    marker_done_d = marker_done_q;
    marker_late_d = marker_late_q;
    last_d        = last_q;
    done_d        = 1'b0;
    buf_d         = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d         = msg_len;
          rem_d         = msg_len;
          idx_d         = 4'd0;
          marker_done_d = 1'b0;
          marker_late_d = 1'b0;
          last_d        = 1'b0;
          state_d       = (msg_len != '0) ? ST_FILL : ST_PAD;
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          buf_d[idx_q] = in_data;
          idx_d        = idx_q + 4'd1;
          rem_d        = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
          if (idx_q == 4'd15) begin
            last_d  = 1'b0;
            state_d = ST_EMIT;
          end else if (rem_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        buf_d[idx_q] = pad_word;
        idx_d        = idx_q + 4'd1;
        if (!marker_done_q) begin
          marker_done_d = 1'b1;
          marker_late_d = (idx_q >= 4'd14);
        end
        if (idx_q == 4'd15) begin
          last_d  = marker_done_q && !marker_late_q;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          if (last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d         = 4'd0;
            marker_late_d = 1'b0;
            state_d       = (rem_q != '0) ? ST_FILL : ST_PAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears any partial block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      rem_q         <= '0;
      len_q         <= '0;
      marker_done_q <= 1'b0;
      marker_late_q <= 1'b0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      buf_q         <= '{default: 32'h0};
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rem_q         <= rem_d;
      len_q         <= len_d;
      marker_done_q <= marker_done_d;
      marker_late_q <= marker_late_d;
      last_q        <= last_d;
      done_q        <= done_d;
      buf_q         <= buf_d;
    end
  end

  // Pack the buffer onto the block bus, w0 in the most significant word.
  for (genvar gi = 0; gi < WORDS_PER_BLK; gi++) begin : g_pack
    assign blk_data[BLK_W-1-32*gi -: 32] = buf_q[gi];
  end

  assign in_ready  = (state_q == ST_FILL);
  assign blk_valid = (state_q == ST_EMIT);
  assign blk_last  = (state_q == ST_EMIT) && last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed testbench for sha256_msg_padder with an expected-block scoreboard.
module tb_sha256_msg_padder;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [511:0]     blk_data;
  logic             blk_valid;
  logic             blk_ready = 1'b0;
  logic             blk_last;
  logic             busy;
  logic             done;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  blk_t        sb[$];
  logic [31:0] msg_q[$];
  int          checks = 0;
  int          failures = 0;

  sha256_msg_padder #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .msg_len(msg_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_last(blk_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference padding: message, marker, zeros up to word 14 mod 16, then 64-bit length.
  task automatic build_expected(input int len);
    logic [31:0] p[$];
    blk_t        b;
    for (int i = 0; i < len; i++) p.push_back(msg_q[i]);
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(len * 32));
    for (int k = 0; k < p.size() / 16; k++) begin
      b.data = '0;
      for (int w = 0; w < 16; w++) b.data[511-32*w -: 32] = p[16*k+w];
      b.last = (k == p.size() / 16 - 1);
      sb.push_back(b);
    end
  endtask

  // Run one message: feed words, consume blocks, compare against scoreboard.
  task automatic run_msg(input string name, input int len, input bit bp, input bit noise);
    int           widx = 0;
    int           vcnt = 0;
    int           cyc = 0;
    int           nblk = 0;
    bit           fin = 0;
    bit           expect_done = 0;
    bit           prev_valid = 0;
    logic [511:0] prev_data = '0;
    blk_t         e;
    build_expected(len);
    @(negedge clk);
    msg_len = LEN_W'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, 512'(busy), 512'(1));
    while (!fin && cyc < 3000) begin
      if (expect_done) begin
        chk({name, "_done"}, 512'(done), 512'(1));
        chk({name, "_idle"}, 512'(busy), 512'(0));
        blk_ready = 1'b0;
        fin = 1;
      end else begin
        chk({name, "_no_early_done"}, 512'(done), 512'(0));
        if (blk_valid) begin
          chk({name, "_in_ready_emit"}, 512'(in_ready), 512'(0));
          if (prev_valid) chk({name, "_stable"}, blk_data, prev_data);
          vcnt++;
          blk_ready = bp ? (vcnt > 5) : 1'b1;
          if (blk_ready) begin
            if (sb.size() == 0) begin
              chk({name, "_extra_block"}, 512'(1), 512'(0));
            end else begin
              e = sb.pop_front();
              chk($sformatf("%s_blk%0d_data", name, nblk), blk_data, e.data);
              chk($sformatf("%s_blk%0d_last", name, nblk), 512'(blk_last), 512'(e.last));
              if (e.last) expect_done = 1;
            end
            nblk++;
            vcnt = 0;
            prev_valid = 0;
          end else begin
            prev_valid = 1;
            prev_data = blk_data;
          end
        end else begin
          blk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b0;
          prev_valid = 0;
        end
        in_valid = (widx < len) && (!bp || $urandom_range(0, 2) != 0);
        in_data = in_valid ? msg_q[widx] : $urandom;
        if (in_valid && in_ready) widx++;
        start = noise && busy && (cyc % 7 == 3);
        msg_len = start ? LEN_W'($urandom_range(1, 40)) : LEN_W'(len);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    blk_ready = 1'b0;
    if (!fin) chk({name, "_timeout"}, 512'(0), 512'(1));
    chk({name, "_sb_empty"}, 512'(sb.size()), 512'(0));
    chk({name, "_words_used"}, 512'(widx), 512'(len));
    $display("msg %s len=%0d blocks=%0d checks=%0d failures=%0d", name, len, nblk, checks, failures);
  endtask

  task automatic fill_random(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back($urandom);
  endtask

  initial begin
    int acc;
    int cyc;
    // Reset values
    #1;
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_last", 512'(blk_last), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_blk_data", blk_data, 512'(0));
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Empty message
    msg_q.delete();
    run_msg("len0", 0, 0, 0);

    // 13 words 1..13
    msg_q.delete();
    for (int i = 1; i <= 13; i++) msg_q.push_back(32'(i));
    run_msg("len13", 13, 0, 0);

    // Marker at word 14 and 15: extra block
    fill_random(14);
    run_msg("len14", 14, 0, 0);
    fill_random(15);
    run_msg("len15", 15, 0, 0);

    // Full block of data
    fill_random(16);
    run_msg("len16", 16, 0, 0);

    // Backpressure, input gaps, start while busy
    fill_random(37);
    run_msg("bp37", 37, 1, 1);
    fill_random(30);
    run_msg("bp30", 30, 1, 1);

    // Reset in the middle of FILL after 7 words
    fill_random(20);
    @(negedge clk);
    msg_len = LEN_W'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 7 && cyc < 100) begin
      in_valid = 1'b1;
      in_data = msg_q[acc];
      if (in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("mid_rst_words", 512'(acc), 512'(7));
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", 512'(in_ready), 512'(0));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("mid_rst_blk_data", blk_data, 512'(0));
    chk("mid_rst_done", 512'(done), 512'(0));
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    msg_q.delete();
    msg_q.push_back(32'hA5A5_1234);
    run_msg("after_rst", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
